ifetch_beat_unpacker: RTL and testbench

//  Sits between the AXI read-data channel of instruction fetch and decode. Takes one 8-beat INCR line burst
//  (64-bit beats, two 32-bit instructions per beat), tags each instruction with its PC and drops instructions

---
 rtl/ifetch_pkg.sv | 21 ++
 rtl/ifetch_beat_unpacker_insn_queue.sv | 71 +++++++
 rtl/ifetch_beat_unpacker.sv | 150 +++++++++++++++
 tb/tb_ifetch_beat_unpacker.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared types for the instruction-fetch beat unpacker.
//   fetch_entry_t  : one queued instruction with its PC and bus-error flag
//   unpack_state_t : burst tracking state of the unpacker
//   LINE_BYTES     : size of one fetched cache line in bytes
package ifetch_pkg;

   localparam int LINE_BYTES = 64;

   typedef struct packed {
      logic [31:0] instr;
      logic [63:0] pc;
      logic        fault;
   } fetch_entry_t;

   typedef enum logic [1:0] {
      IDLE,
      STREAM,
      DRAIN
   } unpack_state_t;

endpackage

// File: rtl/ifetch_beat_unpacker_insn_queue.sv
// insn_queue: circular FIFO of fetch_entry_t accepting up to two pushes and
// one pop per cycle, with a synchronous flush.
// Ports:
//   clk, reset      clock, synchronous active-low reset
//   flush           empty the queue; same-cycle pushes and pop are dropped
//   push_a, entry_a first entry to write this cycle
//   push_b, entry_b second entry (only meaningful together with push_a)
//   pop             remove the head entry (ignored when empty)
//   head            head entry, combinational; all zero when empty
//   count           number of entries held
module insn_queue
   import ifetch_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       push_a,
   input  fetch_entry_t               entry_a,
   input  logic                       push_b,
   input  fetch_entry_t               entry_b,
   input  logic                       pop,
   output fetch_entry_t               head,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   fetch_entry_t    mem_reg [DEPTH];
   logic [PW-1:0]   wr_ptr_reg;
   logic [PW-1:0]   rd_ptr_reg;
   logic [CW-1:0]   count_reg;
   logic [PW-1:0]   wr_ptr_b;
   logic            do_pop;
   logic [1:0]      push_cnt;

   assign wr_ptr_b = wr_ptr_reg + PW'(1);
   assign do_pop   = pop && (count_reg != '0);
   assign push_cnt = {1'b0, push_a} + {1'b0, push_b};

   // Storage holds no reset; entries are only visible through count.
   always_ff @(posedge clk) begin
      if (!flush) begin
         if (push_a) mem_reg[wr_ptr_reg] <= entry_a;
         if (push_b) mem_reg[wr_ptr_b]   <= entry_b;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_reg + PW'(push_cnt);
         rd_ptr_reg <= rd_ptr_reg + PW'(do_pop);
         count_reg  <= count_reg + CW'(push_cnt) - CW'(do_pop);
      end
   end

   // Mask the head when empty so stale or uninitialised storage never leaks out.
   assign head  = (count_reg != '0) ? mem_reg[rd_ptr_reg] : '0;
   assign count = count_reg;

endmodule

// File: rtl/ifetch_beat_unpacker.sv
// ifetch_beat_unpacker: turns one 8-beat, 64-bit AXI read burst of an
// instruction line into a stream of PC-tagged 32-bit instructions, dropping
// those below the requested PC, and hands them to decode one per cycle.
// Ports:
//   clk, reset                 clock, synchronous active-low reset
//   burst_start, burst_pc      new line request accepted; requested PC
//   flush                      redirect: empty queue, discard rest of burst
//   m_axi_r*                   AXI read-data channel (rready is an output)
//   out_valid/out_ready        decode handshake
//   out_instr/out_pc/out_fault head instruction, its PC and bus-error flag
//   burst_done                 pulse the cycle after the rlast beat is taken
//   count                      instructions currently queued
module ifetch_beat_unpacker
   import ifetch_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int INSN_WIDTH = 32,
   parameter int DEPTH      = 16,
   parameter int BEATS      = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       burst_start,
   input  logic [63:0]                burst_pc,
   input  logic                       flush,
   input  logic [DATA_WIDTH-1:0]      m_axi_rdata,
   input  logic [1:0]                 m_axi_rresp,
   input  logic                       m_axi_rlast,
   input  logic                       m_axi_rvalid,
   output logic                       m_axi_rready,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [INSN_WIDTH-1:0]      out_instr,
   output logic [63:0]                out_pc,
   output logic                       out_fault,
   output logic                       burst_done,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int          CW        = $clog2(DEPTH + 1);
   localparam logic [63:0] LINE_MASK = 64'(BEATS * 8 - 1);

   unpack_state_t state_reg, state_next;
   logic [63:0]   beat_pc_reg, beat_pc_next;
   logic [63:0]   skip_pc_reg, skip_pc_next;
   logic          burst_done_reg;

   logic          beat_fire;
   logic          stream_push;
   logic          keep_lo, keep_hi;
   logic          push_a, push_b;
   logic          pop;
   fetch_entry_t  entry_lo, entry_hi, entry_a, head;
   logic [CW-1:0] q_count;
   int            free_slots;

   // Registered count only: a pop in this cycle does not open room for a beat.
   always_comb begin
      free_slots   = DEPTH - int'(q_count);
      m_axi_rready = 1'b0;
      case (state_reg)
         STREAM:  m_axi_rready = (free_slots >= 2);
         DRAIN:   m_axi_rready = 1'b1;
         default: m_axi_rready = 1'b0;
      endcase
   end

   assign beat_fire = m_axi_rvalid && m_axi_rready;

   assign entry_lo = '{instr: m_axi_rdata[INSN_WIDTH-1:0],
                       pc:    beat_pc_reg,
                       fault: |m_axi_rresp};
   assign entry_hi = '{instr: m_axi_rdata[DATA_WIDTH-1:INSN_WIDTH],
                       pc:    beat_pc_reg + 64'd4,
                       fault: |m_axi_rresp};

   // Words below the requested PC are dropped; a kept low word implies a kept high word.
   assign keep_lo     = (beat_pc_reg >= skip_pc_reg);
   assign keep_hi     = ((beat_pc_reg + 64'd4) >= skip_pc_reg);
   assign stream_push = (state_reg == STREAM) && beat_fire && !flush;

   // Kept words are packed into slot a first so the queue always sees a then b.
   assign push_a  = stream_push && (keep_lo || keep_hi);
   assign push_b  = stream_push && keep_lo && keep_hi;
   assign entry_a = keep_lo ? entry_lo : entry_hi;

   assign out_valid = (q_count != '0);
   assign pop       = out_valid && out_ready;

   insn_queue #(
      .DEPTH (DEPTH)
   ) u_queue (
      .clk     (clk),
      .reset   (reset),
      .flush   (flush),
      .push_a  (push_a),
      .entry_a (entry_a),
      .push_b  (push_b),
      .entry_b (entry_hi),
      .pop     (pop),
      .head    (head),
      .count   (q_count)
   );

   always_comb begin
      state_next   = state_reg;
      beat_pc_next = beat_pc_reg;
      skip_pc_next = skip_pc_reg;
      case (state_reg)
         IDLE: begin
            // A flush in the same cycle belongs to the old stream: do not start.
            if (burst_start && !flush) begin
               state_next   = STREAM;
               beat_pc_next = burst_pc & ~LINE_MASK;
               skip_pc_next = burst_pc & ~64'h3;
            end
         end
         STREAM: begin
            if (beat_fire) beat_pc_next = beat_pc_reg + 64'd8;
            if (beat_fire && m_axi_rlast) state_next = IDLE;
            else if (flush)               state_next = DRAIN;
         end
         DRAIN: begin
            if (beat_fire && m_axi_rlast) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg      <= IDLE;
         beat_pc_reg    <= '0;
         skip_pc_reg    <= '0;
         burst_done_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         beat_pc_reg    <= beat_pc_next;
         skip_pc_reg    <= skip_pc_next;
         burst_done_reg <= beat_fire && m_axi_rlast;
      end
   end

   assign out_instr  = head.instr;
   assign out_pc     = head.pc;
   assign out_fault  = head.fault;
   assign burst_done = burst_done_reg;
   assign count      = q_count;

endmodule

// File: tb/tb_ifetch_beat_unpacker.sv
// Bench for ifetch_beat_unpacker: scenario table plus randomized bursts, all
// checked cycle by cycle against a queue-based model of the fetch stream.
module tb_ifetch_beat_unpacker;
   import ifetch_pkg::*;

   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        burst_start = 1'b0;
   logic [63:0] burst_pc = '0;
   logic        flush = 1'b0;
   logic [63:0] m_axi_rdata = '0;
   logic [1:0]  m_axi_rresp = '0;
   logic        m_axi_rlast = 1'b0;
   logic        m_axi_rvalid = 1'b0;
   logic        m_axi_rready;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_instr;
   logic [63:0] out_pc;
   logic        out_fault;
   logic        burst_done;
   logic [4:0]  count;

   always #5 clk = ~clk;

   ifetch_beat_unpacker #(
      .DATA_WIDTH (64),
      .INSN_WIDTH (32),
      .DEPTH      (DEPTH),
      .BEATS      (8)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .burst_start  (burst_start),
      .burst_pc     (burst_pc),
      .flush        (flush),
      .m_axi_rdata  (m_axi_rdata),
      .m_axi_rresp  (m_axi_rresp),
      .m_axi_rlast  (m_axi_rlast),
      .m_axi_rvalid (m_axi_rvalid),
      .m_axi_rready (m_axi_rready),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_instr    (out_instr),
      .out_pc       (out_pc),
      .out_fault    (out_fault),
      .burst_done   (burst_done),
      .count        (count)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] instr;
      logic [63:0] pc;
      logic        fault;
   } exp_t;

   exp_t        exp_q[$];
   logic [63:0] beat_data [8];

   typedef struct {
      logic [63:0] pc;
      int          err_beat;     // beat carrying rresp=2'b10, -1 none
      int          flush_after;  // flush once this beat index is consumed, -1 none
      int          rdy_pct;
      int          vld_pct;
      int          hold;         // cycles out_ready is forced low
      bit          drain;        // wait for the queue to empty before returning
      int          exp_deliv;    // -1 = not checked
      logic [63:0] exp_first;    // all ones = not checked
      int          peak_min;
      int          peak_max;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Drives one line burst and checks every cycle against the model.
   // Caller must be aligned 1 time unit after a rising edge.
   task automatic run_burst(input vec_t v, input bit patterned,
                            output int delivered, output logic [63:0] first_pc,
                            output int peak, output int blocked);
      bit          active, draining, flushed, done_pend, got_first;
      bit          exp_rready, exp_valid, fire, popv, do_flush, start;
      logic [63:0] line, skip, lo_pc;
      logic [31:0] lo_w, hi_w;
      int          beat, cyc, idx;
      exp_t        e;
      active = 0; draining = 0; flushed = 0; done_pend = 0; got_first = 0;
      beat = 0; cyc = 0; line = '0; skip = '0;
      delivered = 0; first_pc = '1; peak = exp_q.size(); blocked = 0;
      for (int i = 0; i < 8; i++) begin
         lo_w = patterned ? 32'h1000_0000 + 32'(2 * i)     : $urandom;
         hi_w = patterned ? 32'h1000_0000 + 32'(2 * i + 1) : $urandom;
         beat_data[i] = {hi_w, lo_w};
      end
      while (cyc == 0 || active || done_pend || (v.drain && exp_q.size() != 0)) begin
         if (cyc > 3000) begin
            check("cycle_budget", 64'(cyc), 64'd3000);
            break;
         end
         start        = (cyc == 0);
         do_flush     = (v.flush_after >= 0) && !flushed && active && (beat == v.flush_after + 1);
         burst_start  = start;
         burst_pc     = start ? v.pc : {$urandom, $urandom};
         flush        = do_flush;
         idx          = (beat < 8) ? beat : 0;
         m_axi_rvalid = active && (beat < 8) && ($urandom_range(99) < v.vld_pct);
         m_axi_rdata  = beat_data[idx];
         m_axi_rresp  = (beat == v.err_beat) ? 2'b10 : 2'b00;
         m_axi_rlast  = (beat == 7);
         out_ready    = (cyc >= v.hold) && ($urandom_range(99) < v.rdy_pct);
         #1;
         exp_rready = active && (draining || (DEPTH - exp_q.size()) >= 2);
         exp_valid  = (exp_q.size() != 0);
         check("rready", 64'(m_axi_rready), 64'(exp_rready));
         check("out_valid", 64'(out_valid), 64'(exp_valid));
         check("count", 64'(count), 64'(exp_q.size()));
         check("burst_done", 64'(burst_done), 64'(done_pend));
         if (active && !draining && m_axi_rvalid && !exp_rready) blocked++;
         fire = m_axi_rvalid && exp_rready;
         popv = exp_valid && out_ready;
         if (popv) begin
            e = exp_q[0];
            check("out_instr", 64'(out_instr), 64'(e.instr));
            check("out_pc", out_pc, e.pc);
            check("out_fault", 64'(out_fault), 64'(e.fault));
            if (!do_flush) begin
               void'(exp_q.pop_front());
               delivered++;
               if (!got_first) begin
                  first_pc  = e.pc;
                  got_first = 1;
               end
            end
         end
         if (do_flush) begin
            exp_q.delete();
            flushed = 1;
         end
         done_pend = 0;
         if (fire) begin
            if (!draining && !do_flush) begin
               lo_pc = line + 64'(8 * beat);
               if (lo_pc >= skip)
                  exp_q.push_back('{beat_data[idx][31:0], lo_pc, beat == v.err_beat});
               if (lo_pc + 64'd4 >= skip)
                  exp_q.push_back('{beat_data[idx][63:32], lo_pc + 64'd4, beat == v.err_beat});
            end
            beat++;
            if (beat == 8) begin
               active    = 0;
               draining  = 0;
               done_pend = 1;
            end
         end
         if (do_flush && active) draining = 1;
         if (start && !active && !do_flush) begin
            active = 1;
            line   = v.pc & ~64'h3F;
            skip   = v.pc & ~64'h3;
         end
         if (exp_q.size() > peak) peak = exp_q.size();
         @(posedge clk);
         #1;
         cyc++;
      end
      burst_start  = 0;
      flush        = 0;
      m_axi_rvalid = 0;
      m_axi_rlast  = 0;
      m_axi_rresp  = 0;
      out_ready    = 0;
   endtask

   vec_t        vecs [7];
   vec_t        rv;
   int          deliv, peak, blocked;
   logic [63:0] first;

   initial begin
      //          pc        err flush rdy vld hold drain deliv first       pkmin pkmax
      vecs[0] = '{64'h1000, -1, -1, 100, 100,   0, 1, 16, 64'h1000,     0, 16};
      vecs[1] = '{64'h1014, -1, -1, 100, 100,   0, 1, 11, 64'h1014,     0, 11};
      vecs[2] = '{64'h1000,  5, -1, 100, 100,   0, 1, 16, 64'h1000,     0, 16};
      vecs[3] = '{64'h1000, -1,  3, 100, 100, 999, 1,  0, '1,           8, 16};
      // Fill the queue with no consumer, then start a second line that must stall.
      vecs[4] = '{64'h1000, -1, -1, 100, 100, 999, 0,  0, '1,          16, 16};
      vecs[5] = '{64'h1040, -1, -1, 100, 100,  30, 1, 32, 64'h1000,    16, 16};
      vecs[6] = '{64'h103C, -1, -1,  50,  60,   0, 1,  1, 64'h103C,     0,  1};

      repeat (3) @(posedge clk);
      #1;
      check("reset_rready", 64'(m_axi_rready), 64'd0);
      check("reset_out_valid", 64'(out_valid), 64'd0);
      check("reset_count", 64'(count), 64'd0);
      check("reset_burst_done", 64'(burst_done), 64'd0);
      check("reset_out_pc", out_pc, 64'd0);
      check("reset_out_instr", 64'(out_instr), 64'd0);
      reset = 1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 7; i++) begin
         run_burst(vecs[i], 1'b1, deliv, first, peak, blocked);
         $display("burst %0d pc=%0h delivered=%0d first_pc=%0h peak=%0d stalled=%0d",
                  i, vecs[i].pc, deliv, first, peak, blocked);
         if (vecs[i].exp_deliv >= 0) check("delivered", 64'(deliv), 64'(vecs[i].exp_deliv));
         if (vecs[i].exp_first !== '1) check("first_pc", first, vecs[i].exp_first);
         check("peak_in_range", 64'(peak >= vecs[i].peak_min && peak <= vecs[i].peak_max), 64'd1);
         if (i == 5) check("stalled_when_full", 64'(blocked > 0), 64'd1);
      end

      // flush and burst_start together in IDLE: the new burst is not latched.
      burst_start = 1; burst_pc = 64'h3000; flush = 1;
      @(posedge clk);
      #1;
      burst_start = 0; flush = 0; m_axi_rvalid = 1;
      #1;
      check("flush_start_rready", 64'(m_axi_rready), 64'd0);
      check("flush_start_count", 64'(count), 64'd0);
      m_axi_rvalid = 0;
      @(posedge clk);
      #1;

      // Reset in the middle of a burst with six instructions queued.
      burst_start = 1; burst_pc = 64'h2000; out_ready = 0;
      @(posedge clk);
      #1;
      burst_start = 0;
      for (int b = 0; b < 3; b++) begin
         m_axi_rvalid = 1;
         m_axi_rdata  = {32'hA000_0000 + 32'(b), 32'hB000_0000 + 32'(b)};
         m_axi_rlast  = 0;
         @(posedge clk);
         #1;
      end
      m_axi_rvalid = 0;
      #1;
      check("pre_reset_count", 64'(count), 64'd6);
      check("pre_reset_head_pc", out_pc, 64'h2000);
      reset = 0;
      @(posedge clk);
      #1;
      reset = 1;
      check("mid_reset_out_valid", 64'(out_valid), 64'd0);
      check("mid_reset_count", 64'(count), 64'd0);
      check("mid_reset_rready", 64'(m_axi_rready), 64'd0);
      check("mid_reset_out_pc", out_pc, 64'd0);
      m_axi_rvalid = 1; m_axi_rlast = 1;
      @(posedge clk);
      #1;
      check("post_reset_no_absorb", 64'(m_axi_rready), 64'd0);
      check("post_reset_count", 64'(count), 64'd0);
      m_axi_rvalid = 0; m_axi_rlast = 0;
      @(posedge clk);
      #1;
      exp_q.delete();

      for (int k = 0; k < 12; k++) begin
         rv.pc          = 64'h8000 + 64'(64 * k) + 64'(4 * $urandom_range(15));
         rv.err_beat    = int'($urandom_range(8)) - 1;
         rv.flush_after = ($urandom_range(3) == 0) ? int'($urandom_range(6)) : -1;
         rv.rdy_pct     = 20 + int'($urandom_range(80));
         rv.vld_pct     = 20 + int'($urandom_range(80));
         rv.hold        = 0;
         rv.drain       = 1;
         rv.exp_deliv   = -1;
         rv.exp_first   = '1;
         rv.peak_min    = 0;
         rv.peak_max    = DEPTH;
         run_burst(rv, 1'b0, deliv, first, peak, blocked);
         $display("random burst %0d pc=%0h err=%0d flush=%0d delivered=%0d peak=%0d",
                  k, rv.pc, rv.err_beat, rv.flush_after, deliv, peak);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
